// File: rtl/neuron_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_accum
// Description : Serial multiply-accumulate stage computing one neuron
//               pre-activation z = bias + sum(x_i * w_i) over a streamed
//               vector of (x, w) pairs, in sign-magnitude fixed point
//               (Q fractional bits, bit N-1 = sign).
//               Stage 1 forms the truncated/saturated product, stage 2
//               accumulates in N+GUARD two's complement, and the final sum is
//               converted back to saturated sign-magnitude.
// Ports       : clk, rst       - clock (rising edge), sync active-high reset
//               in_valid/ready - input beat handshake
//               in_x, in_w     - activation and weight (sign-magnitude)
//               in_bias        - bias, sampled on a vector's first beat
//               in_last        - final beat of the vector
//               out_valid/ready- result handshake
//               out_data       - z, sign-magnitude, saturated
//               out_ovf        - sticky per vector: product/sum/output saturated
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_accum #(
  parameter int Q     = 24,
  parameter int N     = 32,
  parameter int GUARD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_w,
  input  logic [N-1:0] in_bias,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
);

  localparam int ACC_W = N + GUARD;
  localparam int MW    = N - 1;
  localparam int PW    = 2 * MW;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Sign-magnitude to two's complement; a negative zero maps to plain zero.
  function automatic logic [ACC_W-1:0] sm_to_tc(input logic sgn, input logic [MW-1:0] mag);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-MW){1'b0}}, mag};
    return sgn ? -ext : ext;
  endfunction

  state_e             state_q, state_d;
  logic               first_q, first_d;
  logic               p_valid_q, p_valid_d;
  logic               p_first_q, p_first_d;
  logic               p_last_q, p_last_d;
  logic               p_ovf_q, p_ovf_d;
  logic [ACC_W-1:0]   p_prod_q, p_prod_d;
  logic [ACC_W-1:0]   p_bias_q, p_bias_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [N-1:0]       out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic [PW-1:0]      prod_full;
  logic               prod_hi_ovf;
  logic [MW-1:0]      prod_mag;
  logic [ACC_W-1:0]   base;
  logic [ACC_W:0]     sum_wide;
  logic               sum_sat;
  logic [ACC_W-1:0]   sum_clip;
  logic [ACC_W-1:0]   acc_abs;
  logic               out_sat;
  logic [MW-1:0]      out_mag;
  logic               stage_ovf;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign accept    = in_valid && in_ready;

  // Stage 1: magnitude product, keep the Q-aligned window, saturate if any
  // bit above the window is set.
  assign prod_full   = {{MW{1'b0}}, in_x[MW-1:0]} * {{MW{1'b0}}, in_w[MW-1:0]};
  assign prod_hi_ovf = |prod_full[PW-1:Q+MW];
  assign prod_mag    = prod_hi_ovf ? {MW{1'b1}} : prod_full[Q+MW-1:Q];

  // Stage 2: sign-extended add with clip to the accumulator's limits.
  assign base     = p_first_q ? p_bias_q : acc_q;
  assign sum_wide = {base[ACC_W-1], base} + {p_prod_q[ACC_W-1], p_prod_q};
  assign sum_sat  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sum_clip = !sum_sat        ? sum_wide[ACC_W-1:0] :
                    sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};

  // Output conversion straight from the stage-2 result so the finished value
  // is registered on the same edge the last product is accumulated.
  assign acc_abs   = sum_clip[ACC_W-1] ? -sum_clip : sum_clip;
  assign out_sat   = |acc_abs[ACC_W-1:MW];
  assign out_mag   = out_sat ? {MW{1'b1}} : acc_abs[MW-1:0];
  assign stage_ovf = (p_first_q ? 1'b0 : acc_ovf_q) | p_ovf_q | sum_sat;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    p_valid_d  = accept;
    p_first_d  = p_first_q;
    p_last_d   = p_last_q;
    p_ovf_d    = p_ovf_q;
    p_prod_d   = p_prod_q;
    p_bias_d   = p_bias_q;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    if (accept) begin
      p_first_d = first_q;
      p_last_d  = in_last;
      p_ovf_d   = prod_hi_ovf;
      p_prod_d  = sm_to_tc(in_x[N-1] ^ in_w[N-1], prod_mag);
      if (first_q) begin
        p_bias_d = sm_to_tc(in_bias[N-1], in_bias[MW-1:0]);
      end
      first_d = 1'b0;
    end

    if (p_valid_q) begin
      acc_d     = sum_clip;
      acc_ovf_d = stage_ovf;
      if (p_last_q) begin
        // acc == 0 has a clear sign bit, so zero always comes out as +0.
        out_data_d = {sum_clip[ACC_W-1], out_mag};
        out_ovf_d  = stage_ovf | out_sat;
      end
    end

    case (state_q)
      ST_ACC: begin
        if (accept && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (p_valid_q && p_last_q) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d   = ST_ACC;
          first_d   = 1'b1;
          acc_ovf_d = 1'b0;
          out_ovf_d = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      first_q    <= 1'b1;
      p_valid_q  <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      p_ovf_q    <= 1'b0;
      p_prod_q   <= '0;
      p_bias_q   <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      p_valid_q  <= p_valid_d;
      p_first_q  <= p_first_d;
      p_last_q   <= p_last_d;
      p_ovf_q    <= p_ovf_d;
      p_prod_q   <= p_prod_d;
      p_bias_q   <= p_bias_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac_accum
// Description : Directed self-checking bench for neuron_mac_accum with
//               hand-computed expected pre-activation values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_w;
  logic [31:0] in_bias;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_mac_accum #(.Q(24), .N(32), .GUARD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_bias   (in_bias),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one beat; called #1 after a rising edge, returns #1 after the accepting edge.
  task automatic beat(input logic [31:0] x, input logic [31:0] w, input logic [31:0] b,
                      input logic last);
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_bias  = b;
    in_last  = last;
    check("beat_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bounded wait for a result, compare it, then consume it.
  task automatic take(input string tag, input logic [31:0] exp_d, input logic exp_ovf);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    in_bias   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);

    // Test 1: 0.25 + 2.0*0.5 + 0.5*(-1.0) = 0.75, with latency check.
    beat(32'h0200_0000, 32'h0080_0000, 32'h0040_0000, 1'b0);
    beat(32'h0080_0000, 32'h8100_0000, 32'h0040_0000, 1'b1);
    check("t1_lat_k", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_lat_k1", {31'd0, out_valid}, 32'd1);
    take("t1", 32'h00C0_0000, 1'b0);

    // Test 2: -2.0 + (-1.0)*(-1.0) = -1.0
    beat(32'h8100_0000, 32'h8100_0000, 32'h8200_0000, 1'b1);
    take("t2", 32'h8100_0000, 1'b0);

    // Test 3: 100*100 saturates the product and the output.
    beat(32'h6400_0000, 32'h6400_0000, 32'h0000_0000, 1'b1);
    take("t3", 32'h7FFF_FFFF, 1'b1);

    // Test 4: stall on output while junk is offered at the input.
    beat(32'h0200_0000, 32'h0080_0000, 32'h0040_0000, 1'b0);
    beat(32'h0080_0000, 32'h8100_0000, 32'h0040_0000, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_x     = 32'h1000_0000;
    in_w     = 32'h1000_0000;
    in_bias  = 32'h1000_0000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_stall_ready", {31'd0, in_ready}, 32'd0);
      check("t4_stall_data", out_data, 32'h00C0_0000);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("t4", 32'h00C0_0000, 1'b0);
    beat(32'h8100_0000, 32'h8100_0000, 32'h8200_0000, 1'b1);
    take("t4b", 32'h8100_0000, 1'b0);

    // Test 5: reset in the middle of a vector leaves no residue.
    beat(32'h0200_0000, 32'h0080_0000, 32'h0040_0000, 1'b0);
    beat(32'h0080_0000, 32'h8100_0000, 32'h0040_0000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_out_data", out_data, 32'd0);
    check("t5_out_ovf", {31'd0, out_ovf}, 32'd0);
    beat(32'h8100_0000, 32'h8100_0000, 32'h8200_0000, 1'b1);
    take("t5", 32'h8100_0000, 1'b0);

    // Test 6: idle gaps between beats; bias on a later beat must be ignored.
    beat(32'h0200_0000, 32'h0080_0000, 32'h0040_0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    beat(32'h0080_0000, 32'h8100_0000, 32'h7F00_0000, 1'b1);
    take("t6", 32'h00C0_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
